// File: rtl/seq_detect_param.sv
// Two-line A/B symbol sequence detector with synchronized inputs, runtime-loadable
// pattern/length, optional overlap and edge-only symbol mode, and saturating match count.
module seq_detect_param #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PAT     = 8'b0000_1011,
    parameter int                 DEF_LEN     = 4,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               a,
    input  logic               b,
    input  logic [MAX_LEN-1:0] pat_sym,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    input  logic               edge_mode,
    input  logic               cfg_load,
    input  logic               clr_cnt,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [LEN_W-1:0]   fill
);

    // class   | meaning
    // CLS_IDLE| sync lines 00 or 11, never a symbol
    // CLS_A   | sa=1, sb=0
    // CLS_B   | sa=0, sb=1
    typedef enum logic [1:0] {CLS_IDLE, CLS_A, CLS_B} cls_t;

    logic [SYNC_STAGES-1:0] sync_a, sync_b;
    logic                   sa, sb;
    cls_t                   cls_cur, cls_prev, cls_prev_n;

    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_ovl, cfg_edge;

    logic [MAX_LEN-1:0] hist, hist_n, hist_shift, len_mask;
    logic [LEN_W-1:0]   fill_n, fill_inc, len_clamped;
    logic [CNT_W-1:0]   cnt_n;
    logic               is_sym, hit, match_n;

    assign sa = sync_a[SYNC_STAGES-1];
    assign sb = sync_b[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], b};
        end
    end

    assign len_clamped = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cfg_pat  <= DEF_PAT;
            cfg_len  <= LEN_W'(DEF_LEN);
            cfg_ovl  <= 1'b1;
            cfg_edge <= 1'b0;
        end else if (cfg_load) begin
            cfg_pat  <= pat_sym;
            cfg_len  <= len_clamped;
            cfg_ovl  <= overlap;
            cfg_edge <= edge_mode;
        end
    end

    always_comb begin
        cls_cur = CLS_IDLE;
        if (sa && !sb) begin
            cls_cur = CLS_A;
        end else if (!sa && sb) begin
            cls_cur = CLS_B;
        end

        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < cfg_len);
        end

        is_sym     = (cls_cur != CLS_IDLE) && (!cfg_edge || (cls_cur != cls_prev));
        hist_shift = {hist[MAX_LEN-2:0], cls_cur == CLS_A};
        fill_inc   = (fill >= cfg_len) ? cfg_len : fill + LEN_W'(1);
        hit        = (cfg_len != '0) && (fill_inc >= cfg_len) &&
                     (((hist_shift ^ cfg_pat) & len_mask) == '0);

        hist_n     = hist;
        fill_n     = fill;
        cls_prev_n = cls_cur;
        match_n    = 1'b0;
        if (cfg_load) begin
            // a symbol arriving with the load belongs to the old configuration
            hist_n     = '0;
            fill_n     = '0;
            cls_prev_n = CLS_IDLE;
        end else if (is_sym) begin
            hist_n  = hist_shift;
            fill_n  = fill_inc;
            match_n = hit;
            if (hit && !cfg_ovl) begin
                hist_n = '0;
                fill_n = '0;
            end
        end

        cnt_n = match_cnt;
        if (clr_cnt) begin
            cnt_n = match_n ? CNT_W'(1) : '0;
        end else if (match_n && !(&match_cnt)) begin
            cnt_n = match_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist      <= '0;
            fill      <= '0;
            cls_prev  <= CLS_IDLE;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            hist      <= hist_n;
            fill      <= fill_n;
            cls_prev  <= cls_prev_n;
            match     <= match_n;
            match_cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: symbol-queue reference model checked every cycle,
// plus directed scenarios with hand-computed pulse counts, latency and fill values.
module tb_seq_detect_param;

    localparam int S  = 2;
    localparam int ML = 8;
    localparam int CW = 2;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          a, b;
    logic [ML-1:0] pat_sym;
    logic [LW-1:0] pat_len;
    logic          overlap, edge_mode, cfg_load, clr_cnt;
    logic          match;
    logic [CW-1:0] match_cnt;
    logic [LW-1:0] fill;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_n       = 0;
    int pulses      = 0;

    seq_detect_param #(
        .MAX_LEN    (ML),
        .SYNC_STAGES(S),
        .CNT_W      (CW),
        .DEF_PAT    (8'b0000_1011),
        .DEF_LEN    (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .a         (a),
        .b         (b),
        .pat_sym   (pat_sym),
        .pat_len   (pat_len),
        .overlap   (overlap),
        .edge_mode (edge_mode),
        .cfg_load  (cfg_load),
        .clr_cnt   (clr_cnt),
        .match     (match),
        .match_cnt (match_cnt),
        .fill      (fill)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: raw inputs delayed S edges, history kept as a symbol queue.
    logic [1:0]    dly_q[$];
    bit            hist_q[$];
    logic [ML-1:0] m_pat;
    int            m_len;
    bit            m_ov, m_em;
    int            prev_cls;
    bit            exp_match;
    int            exp_cnt;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dly_q = {};
            for (int i = 0; i < S; i++) dly_q.push_back(2'b00);
            hist_q    = {};
            m_pat     = 8'b0000_1011;
            m_len     = 4;
            m_ov      = 1'b1;
            m_em      = 1'b0;
            prev_cls  = 0;
            exp_match = 1'b0;
            exp_cnt   = 0;
        end else begin
            logic [1:0] ab;
            int         cls;
            bit         mt;
            dly_q.push_back({a, b});
            ab  = dly_q.pop_front();
            cls = (ab == 2'b10) ? 1 : (ab == 2'b01) ? 2 : 0;
            mt  = 1'b0;
            if (cfg_load) begin
                m_pat    = pat_sym;
                m_len    = (int'(pat_len) > ML) ? ML : int'(pat_len);
                m_ov     = overlap;
                m_em     = edge_mode;
                hist_q   = {};
                prev_cls = 0;
            end else begin
                if (cls != 0 && (!m_em || cls != prev_cls)) begin
                    hist_q.push_back(cls == 1);
                    if (hist_q.size() > ML) void'(hist_q.pop_front());
                    if (m_len > 0 && hist_q.size() >= m_len) begin
                        mt = 1'b1;
                        for (int i = 0; i < m_len; i++)
                            if (hist_q[hist_q.size() - 1 - i] != m_pat[i]) mt = 1'b0;
                    end
                    if (mt && !m_ov) hist_q = {};
                end
                prev_cls = cls;
            end
            exp_match = mt;
            if (clr_cnt) exp_cnt = mt ? 1 : 0;
            else if (mt && exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
    end

    always @(negedge clk) begin
        int exp_fill;
        exp_fill = (hist_q.size() < m_len) ? hist_q.size() : m_len;
        check("match", int'(match), int'(exp_match));
        check("match_cnt", int'(match_cnt), exp_cnt);
        check("fill", int'(fill), exp_fill);
    end

    always @(posedge clk) begin
        cyc_n++;
        #1;
        if (match === 1'b1) pulses++;
    end

    task automatic drive(input logic va, input logic vb, input int n);
        a = va;
        b = vb;
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [ML-1:0] p, input logic [LW-1:0] l,
                        input logic ov, input logic em);
        pat_sym   = p;
        pat_len   = l;
        overlap   = ov;
        edge_mode = em;
        cfg_load  = 1'b1;
        @(negedge clk);
        cfg_load  = 1'b0;
    endtask

    task automatic clear_count();
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
    endtask

    initial begin
        int            t0, lat;
        logic [ML-1:0] p;

        a = 0; b = 0; pat_sym = '0; pat_len = '0; overlap = 0; edge_mode = 0;
        cfg_load = 0; clr_cnt = 0; resetn = 0;
        repeat (3) @(negedge clk);
        resetn = 1;
        check("rst_match", int'(match), 0);
        check("rst_cnt", int'(match_cnt), 0);
        check("rst_fill", int'(fill), 0);

        // Default pattern A,B,A,A in level mode; last A timed for latency.
        drive(1, 0, 1); drive(0, 0, 1); drive(0, 1, 1); drive(0, 0, 1);
        drive(1, 0, 1); drive(0, 0, 1);
        a = 1; b = 0; t0 = cyc_n;
        @(negedge clk);
        a = 0;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            if (match === 1'b1 && lat < 0) lat = cyc_n - t0;
            @(negedge clk);
        end
        check("latency", lat, S + 1);
        check("dflt_cnt", int'(match_cnt), 1);

        // Pattern A,A with and without overlap.
        load(8'b11, 2, 1, 0); pulses = 0;
        drive(1, 0, 4); drive(0, 0, 6);
        check("ovl1_pulses", pulses, 3);
        load(8'b11, 2, 0, 0); pulses = 0;
        drive(1, 0, 4); drive(0, 0, 6);
        check("ovl0_pulses", pulses, 2);

        // Pattern A,B in edge mode then level mode.
        load(8'b10, 2, 1, 1); pulses = 0;
        drive(1, 0, 5); drive(0, 1, 5); drive(0, 0, 5);
        check("edge_pulses", pulses, 1);
        load(8'b10, 2, 1, 0); pulses = 0;
        drive(1, 0, 5); drive(0, 1, 5); drive(0, 0, 5);
        check("level_pulses", pulses, 1);
        check("level_fill", int'(fill), 2);

        // Load coincident with the completing symbol.
        load(8'b11, 2, 1, 0); drive(0, 0, 2); pulses = 0;
        a = 1; b = 0;
        @(negedge clk);
        @(negedge clk);
        a = 0;
        @(negedge clk);
        cfg_load = 1;
        @(negedge clk);
        cfg_load = 0;
        drive(0, 0, 5);
        check("load_coinc_pulses", pulses, 0);
        check("load_coinc_fill", int'(fill), 0);

        // Zero length disables matching.
        load(8'hFF, 0, 1, 0); pulses = 0;
        drive(1, 0, 4); drive(0, 1, 2); drive(0, 0, 5);
        check("len0_pulses", pulses, 0);
        check("len0_fill", int'(fill), 0);

        // Over-long length clamps to 8; pattern sent oldest symbol first.
        load(8'hA5, 11, 1, 0); pulses = 0;
        p = 8'hA5;
        for (int i = ML - 1; i >= 0; i--) drive(p[i], !p[i], 1);
        drive(0, 0, 5);
        check("clamp_pulses", pulses, 1);
        check("clamp_fill", int'(fill), 8);

        // 2-bit counter saturation and clear coincident with a match.
        load(8'h01, 1, 1, 0); clear_count(); pulses = 0;
        drive(1, 0, 5); drive(0, 0, 5);
        check("sat_pulses", pulses, 5);
        check("sat_cnt", int'(match_cnt), 3);
        a = 1; b = 0;
        repeat (5) @(negedge clk);
        clr_cnt = 1;
        @(negedge clk);
        check("clr_coinc_cnt", int'(match_cnt), 1);
        check("clr_coinc_match", int'(match), 1);
        clr_cnt = 0;
        drive(0, 0, 5);

        // Reset mid-sequence after A,B,A of the default pattern.
        load(8'b0000_1011, 4, 1, 0);
        drive(1, 0, 1); drive(0, 0, 1); drive(0, 1, 1); drive(0, 0, 1);
        drive(1, 0, 1); drive(0, 0, 4);
        check("pre_rst_fill", int'(fill), 3);
        #2 resetn = 0;
        #1;
        check("async_rst_match", int'(match), 0);
        check("async_rst_cnt", int'(match_cnt), 0);
        check("async_rst_fill", int'(fill), 0);
        @(negedge clk);
        resetn = 1; pulses = 0;
        drive(1, 0, 1); drive(0, 0, 6);
        check("post_rst_pulses", pulses, 0);
        check("post_rst_fill", int'(fill), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
